// File: rtl/dds_mc_phase_gen.sv
// Multi-channel DDS phase generator: round-robin phase accumulators
// with double-buffered settings and a sweep-aligned commit.
module dds_mc_phase_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [1:0]            load_sel,
    input  logic [CH_W-1:0]       load_ch,
    input  logic [ACC_WIDTH-1:0]  load_data,
    input  logic                  update,
    input  logic                  clr_acc,
    output logic [DATA_WIDTH-1:0] phase_out,
    output logic [CH_W-1:0]       ch_out,
    output logic                  out_valid,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    localparam logic [ACC_WIDTH-1:0] QUARTER = ACC_WIDTH'(1) << (ACC_WIDTH - 2);
    localparam logic [CH_W-1:0]      LAST    = CH_W'(NUM_CH - 1);

    state_t                 state;
    logic                   clrLatch;
    logic [CH_W-1:0]        slot;

    logic [ACC_WIDTH-1:0]   accReg   [NUM_CH];
    logic [ACC_WIDTH-1:0]   freqAct  [NUM_CH];
    logic [ACC_WIDTH-1:0]   phaseAct [NUM_CH];
    logic [ACC_WIDTH-1:0]   freqSh   [NUM_CH];
    logic [ACC_WIDTH-1:0]   phaseSh  [NUM_CH];
    logic [NUM_CH-1:0]      modeAct;
    logic [NUM_CH-1:0]      modeSh;

    logic                   commitNow;
    logic                   loadFire;
    logic [ACC_WIDTH-1:0]   curAcc;
    logic [ACC_WIDTH-1:0]   curFreq;
    logic [ACC_WIDTH-1:0]   curPhase;
    logic                   curMode;
    logic [ACC_WIDTH-1:0]   phaseSum;

    // The commit cycle is the enabled PENDING cycle that services slot 0,
    // so channel 0 already sees the new settings and no sweep is mixed.
    always_comb begin
        commitNow = (state == PENDING) && enable && (slot == '0);
        curAcc    = accReg[slot];
        curFreq   = freqAct[slot];
        curPhase  = phaseAct[slot];
        curMode   = modeAct[slot];
        if (commitNow) begin
            curFreq  = freqSh[slot];
            curPhase = phaseSh[slot];
            curMode  = modeSh[slot];
            if (clrLatch) begin
                curAcc = '0;
            end
        end
        phaseSum = curAcc + curPhase - (curMode ? QUARTER : '0);
    end

    always_comb begin
        loadFire = load_valid && load_ready
                && (load_sel != 2'b11)
                && (int'(load_ch) < NUM_CH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freqSh[i]  <= '0;
                phaseSh[i] <= '0;
            end
            modeSh <= '0;
        end else if (loadFire) begin
            unique case (1'b1)
                (load_sel == 2'b00): freqSh[load_ch]  <= load_data;
                (load_sel == 2'b01): phaseSh[load_ch] <= load_data;
                (load_sel == 2'b10): modeSh[load_ch]  <= load_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freqAct[i]  <= '0;
                phaseAct[i] <= '0;
            end
            modeAct <= '0;
        end else if (commitNow) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freqAct[i]  <= freqSh[i];
                phaseAct[i] <= phaseSh[i];
            end
            modeAct <= modeSh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                accReg[i] <= '0;
            end
        end else begin
            if (commitNow && clrLatch) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    accReg[i] <= '0;
                end
            end
            if (enable) begin
                accReg[slot] <= curAcc + curFreq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot      <= '0;
            phase_out <= '0;
            ch_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= enable;
            if (enable) begin
                slot      <= (slot == LAST) ? '0 : slot + 1'b1;
                phase_out <= phaseSum[ACC_WIDTH-1 -: DATA_WIDTH];
                ch_out    <= slot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            clrLatch   <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (update) begin
                        state      <= PENDING;
                        clrLatch   <= clr_acc;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (commitNow) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
